disp_num_scan: RTL and testbench

DISP_NUM_SCAN -- requirements
Module: disp_num_scan

---
 rtl/disp_pkg.sv | 22 ++
 rtl/hex_to_seg.sv | 14 +
 rtl/disp_num_scan.sv | 115 +++++++++++
 tb/tb_disp_num_scan.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the four-digit multiplexed hex display scanner.
package disp_pkg;

  localparam int          NUM_POS = 4;
  localparam logic [7:0]  SEG_OFF = 8'hFF;
  localparam logic [3:0]  AN_OFF  = 4'hF;

  // Display position index; 2-bit arithmetic gives the 3->0 wrap for free.
  typedef logic [1:0] pos_t;

  // Active-low {dp,g,f,e,d,c,b,a} patterns, dp shown off; entry [n] decodes nibble n.
  localparam logic [15:0][7:0] HEX_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Active-low one-hot anode select for a display position.
  function automatic logic [3:0] an_select_n(pos_t pos);
    return ~(4'b0001 << pos);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment {g,f,e,d,c,b,a} decoder.
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  logic [7:0] pattern;

  assign pattern = HEX_SEG_TABLE[hex_i];
  assign seg_o   = pattern[6:0];

endmodule

// File: rtl/disp_num_scan.sv
// Four-digit multiplexed hex display scanner with registered anode/segment drive.
// Optional marquee rotation is compiled in when the MARQUEE_EN macro is defined.
module disp_num_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV_W     = 17,
  parameter int MARQUEE_PERIOD = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] num,
  input  logic [3:0]  point,
  input  logic [3:0]  blank,
  input  logic        rot_en,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam logic [7:0] ROUND_LAST = 8'(MARQUEE_PERIOD - 1);

  logic [SCAN_DIV_W-1:0] presc_q, presc_d;
  pos_t                  sel_q, sel_d;
  pos_t                  rot_q;
  logic [3:0]            an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  tick;
  pos_t                  nib_idx;
  logic [3:0]            nibble;
  logic [6:0]            seg7;

  assign tick = &presc_q;

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    presc_d = presc_q + SCAN_DIV_W'(1);
    sel_d   = sel_q;
    if (tick) begin
      sel_d = sel_q + pos_t'(1);
    end
  end

`ifdef MARQUEE_EN
  logic [7:0] round_q, round_d;
  pos_t       rot_d;
  logic       wrap;

  // A round ends on the tick that moves sel from 3 back to 0.
  assign wrap = tick && (sel_q == pos_t'(NUM_POS - 1));

  always_comb begin
    round_d = round_q;
    rot_d   = rot_q;
    if (rot_en && wrap) begin
      if (round_q >= ROUND_LAST) begin
        round_d = '0;
        rot_d   = rot_q + pos_t'(1);
      end else begin
        round_d = round_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      round_q <= '0;
      rot_q   <= '0;
    end else begin
      round_q <= round_d;
      rot_q   <= rot_d;
    end
  end
`else
  logic [8:0] unused_cfg;

  assign rot_q      = '0;
  assign unused_cfg = {rot_en, ROUND_LAST};
`endif

  // rot and sel update on the same edge, so each drive cycle sees one consistent pair.
  assign nib_idx = sel_q + rot_q;
  assign nibble  = num[{nib_idx, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .hex_i (nibble),
    .seg_o (seg7)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (!blank[sel_q]) begin
      an_d  = an_select_n(sel_q);
      seg_d = {~point[sel_q], seg7};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      sel_q   <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_disp_num_scan.sv
// Directed self-checking bench for disp_num_scan (SCAN_DIV_W=2, MARQUEE_PERIOD=1).
module tb_disp_num_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] num;
  logic [3:0]  point;
  logic [3:0]  blank;
  logic        rot_en;
  logic [3:0]  an;
  logic [7:0]  seg;

  int n_cmp;
  int n_err;

  // Expected drive for num=ABCD with no rotation, indexed by position.
  logic [3:0] exp_an_pos  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] exp_seg_abcd[4] = '{8'hA1, 8'hC6, 8'h83, 8'h88};

  disp_num_scan #(
    .SCAN_DIV_W     (2),
    .MARQUEE_PERIOD (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .num    (num),
    .point  (point),
    .blank  (blank),
    .rot_en (rot_en),
    .an     (an),
    .seg    (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for three clocks and releases it at a falling edge;
  // the next rising edge is clock 1 of the fresh scan.
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    num = 16'hABCD; point = 4'h0; blank = 4'h0; rot_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (an !== 4'hF) begin n_err++; $display("FAIL reset_an: got %h want F", an); end
    n_cmp++;
    if (seg !== 8'hFF) begin n_err++; $display("FAIL reset_seg: got %h want FF", seg); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hE) begin n_err++; $display("FAIL release_an: got %h want E", an); end
    n_cmp++;
    if (seg !== 8'hA1) begin n_err++; $display("FAIL release_seg: got %h want A1", seg); end
  endtask

  task automatic test_scan();
    num = 16'hABCD; point = 4'h0; blank = 4'h0; rot_en = 1'b0;
    apply_reset();
    for (int k = 1; k <= 17; k++) begin
      int pos;
      @(negedge clk);
      pos = ((k - 1) / 4) % 4;
      n_cmp++;
      if (an !== exp_an_pos[pos]) begin
        n_err++; $display("FAIL scan_an k=%0d: got %h want %h", k, an, exp_an_pos[pos]);
      end
      n_cmp++;
      if (seg !== exp_seg_abcd[pos]) begin
        n_err++; $display("FAIL scan_seg k=%0d: got %h want %h", k, seg, exp_seg_abcd[pos]);
      end
    end
  endtask

  task automatic test_point_blank();
    logic [3:0] pb_an [4];
    logic [7:0] pb_seg[4];
    pb_an  = '{4'hE, 4'hD, 4'hF, 4'h7};
    pb_seg = '{8'hA1, 8'h46, 8'hFF, 8'h88};
    num = 16'hABCD; point = 4'b0010; blank = 4'b0100; rot_en = 1'b0;
    apply_reset();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0) begin
        n_cmp++;
        if (an !== pb_an[k/4 - 1]) begin
          n_err++; $display("FAIL pb_an k=%0d: got %h want %h", k, an, pb_an[k/4 - 1]);
        end
        n_cmp++;
        if (seg !== pb_seg[k/4 - 1]) begin
          n_err++; $display("FAIL pb_seg k=%0d: got %h want %h", k, seg, pb_seg[k/4 - 1]);
        end
      end
    end
    point = 4'h0; blank = 4'h0;
  endtask

  task automatic test_live_update();
    num = 16'hABCD; point = 4'h0; blank = 4'h0; rot_en = 1'b0;
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if (seg !== 8'hA1) begin n_err++; $display("FAIL live_before: got %h want A1", seg); end
    num = 16'hABCE;
    @(negedge clk);
    n_cmp++;
    if (seg !== 8'h86) begin n_err++; $display("FAIL live_after: got %h want 86", seg); end
    n_cmp++;
    if (an !== 4'hE) begin n_err++; $display("FAIL live_an: got %h want E", an); end
    num = 16'hABCD;
  endtask

  task automatic test_marquee();
    logic [7:0] want;
    num = 16'hABCD; point = 4'h0; blank = 4'h0; rot_en = 1'b1;
    apply_reset();
    for (int k = 1; k <= 97; k++) begin
      @(negedge clk);
      want = 8'h00;
`ifdef MARQUEE_EN
      case (k)
        1:  want = 8'hA1;
        16: want = 8'h88;
        17: want = 8'hC6;
        33: want = 8'h83;
        49: want = 8'h83;
        65: want = 8'h83;
        81: want = 8'h88;
        97: want = 8'hA1;
        default: want = 8'h00;
      endcase
`else
      case (k)
        1, 17, 33, 49, 65, 81, 97: want = 8'hA1;
        16: want = 8'h88;
        default: want = 8'h00;
      endcase
`endif
      if (want != 8'h00) begin
        n_cmp++;
        if (seg !== want) begin
          n_err++; $display("FAIL marquee_seg k=%0d: got %h want %h", k, seg, want);
        end
      end
      // Pause rotation for two rounds to show rot holds while disabled.
      if (k == 33) rot_en = 1'b0;
      if (k == 65) rot_en = 1'b1;
    end
    rot_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    num = 16'hABCD; point = 4'h0; blank = 4'h0; rot_en = 1'b1;
    apply_reset();
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hF) begin n_err++; $display("FAIL mid_reset_an: got %h want F", an); end
    n_cmp++;
    if (seg !== 8'hFF) begin n_err++; $display("FAIL mid_reset_seg: got %h want FF", seg); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hE) begin n_err++; $display("FAIL mid_restart_an: got %h want E", an); end
    n_cmp++;
    if (seg !== 8'hA1) begin n_err++; $display("FAIL mid_restart_seg: got %h want A1", seg); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (an !== 4'hD) begin n_err++; $display("FAIL mid_pos1_an: got %h want D", an); end
    n_cmp++;
    if (seg !== 8'hC6) begin n_err++; $display("FAIL mid_pos1_seg: got %h want C6", seg); end
    rot_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0; num = 16'h0; point = 4'h0; blank = 4'h0; rot_en = 1'b0;
    test_reset();
    test_scan();
    test_point_blank();
    test_live_update();
    test_marquee();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
